uart_sample_streamer: RTL and testbench

Streams a block of 16-bit samples from the on-chip sample RAM out over the UART link. It reads addresses 0..`end_address` through a synchronous read port and splits each word into two bytes, low byte first. The bytes go to the transmit side of the `communication` block through its `data_in` / `transmit_en` / `transmit_rdy` handshake. It is the return path for filtered data and mirrors the receive-side byte order, which assembles low byte then high byte.

---
 rtl/uart_sample_streamer_if.sv | 40 ++++
 rtl/uart_sample_streamer.sv | 179 +++++++++++++++++
 tb/tb_uart_sample_streamer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sample_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sample_streamer_if
//  Description : Bundles the sample-RAM synchronous read port and the UART
//                transmit handshake used by uart_sample_streamer.
//                master = streamer side, slave = RAM/UART side.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_sample_streamer_if #(
    parameter int ADDR_W = 14
) ();
    // Sample RAM read port (data valid one cycle after rd_en)
    logic              rd_en;
    logic [ADDR_W-1:0] rd_address;
    logic [15:0]       rd_data;

    // UART transmit handshake
    logic [7:0]        data_out;
    logic              transmit_en;
    logic              transmit_rdy;

    modport master (
        output rd_en,
        output rd_address,
        input  rd_data,
        output data_out,
        output transmit_en,
        input  transmit_rdy
    );

    modport slave (
        input  rd_en,
        input  rd_address,
        output rd_data,
        input  data_out,
        input  transmit_en,
        output transmit_rdy
    );
endinterface
`default_nettype wire

// File: rtl/uart_sample_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sample_streamer
//  Description : Reads 16-bit samples from addresses 0..end_address of the
//                sample RAM and sends each as two UART bytes, low byte first,
//                using a transmit_en / transmit_rdy handshake. Aborts on
//                request and flags a sticky error on acknowledge timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sample_streamer #(
    parameter int ADDR_W      = 14,
    parameter int ACK_TIMEOUT = 1024
) (
    input  wire                  CLOCK_50,
    input  wire                  RESET_N,
    input  wire                  start,
    input  wire                  abort,
    input  wire     [ADDR_W-1:0] end_address,
    uart_sample_streamer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_LATCH     = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_NEXT      = 3'd6
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] end_q;
    logic [15:0]       word_q;
    logic              hi_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_en_q;
    logic [7:0]        data_out_q;
    logic              transmit_en_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    // Next sample address; the end check happens on addr_q before this is used,
    // so the last address of the full range never wraps back to 0.
    logic [ADDR_W-1:0] addr_d;
    assign addr_d = addr_q + ADDR_W'(1);

    // Sequencer: one state register with all outputs registered alongside it.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            end_q         <= '0;
            word_q        <= '0;
            hi_q          <= 1'b0;
            cnt_q         <= '0;
            rd_en_q       <= 1'b0;
            data_out_q    <= 8'h00;
            transmit_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below re-asserts them.
            rd_en_q       <= 1'b0;
            transmit_en_q <= 1'b0;
            done_q        <= 1'b0;

            if (abort && (state_q != S_IDLE)) begin
                // Drop everything; a byte already taken by the UART still
                // finishes on the line, the rest of the sample is discarded.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state_q <= S_READ;
                            end_q   <= end_address;
                            addr_q  <= '0;
                            rd_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                            error_q <= 1'b0;
                        end
                    end

                    S_READ: begin
                        state_q <= S_LATCH;
                    end

                    S_LATCH: begin
                        // rd_data is valid now; issue the low-byte request
                        // directly from it so the pulse lands in the first
                        // SEND cycle when the transmitter is already idle.
                        word_q  <= bus.rd_data;
                        hi_q    <= 1'b0;
                        state_q <= S_SEND;
                        if (bus.transmit_rdy) begin
                            transmit_en_q <= 1'b1;
                            data_out_q    <= bus.rd_data[7:0];
                        end
                    end

                    S_SEND: begin
                        if (transmit_en_q) begin
                            state_q <= S_WAIT_ACK;
                            cnt_q   <= '0;
                        end else if (bus.transmit_rdy) begin
                            transmit_en_q <= 1'b1;
                            data_out_q    <= hi_q ? word_q[15:8] : word_q[7:0];
                        end
                    end

                    S_WAIT_ACK: begin
                        if (!bus.transmit_rdy) begin
                            state_q <= S_WAIT_DONE;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end

                    S_WAIT_DONE: begin
                        if (bus.transmit_rdy) begin
                            if (!hi_q) begin
                                // Transmitter just went idle, so the high-byte
                                // request can be issued on the SEND cycle.
                                hi_q          <= 1'b1;
                                state_q       <= S_SEND;
                                transmit_en_q <= 1'b1;
                                data_out_q    <= word_q[15:8];
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end
                    end

                    S_NEXT: begin
                        if (addr_q == end_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_d;
                            rd_en_q <= 1'b1;
                            state_q <= S_READ;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.rd_address  = addr_q;
    assign bus.data_out    = data_out_q;
    assign bus.transmit_en = transmit_en_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_sample_streamer
//  Description : Self-checking bench for uart_sample_streamer with a sample
//                RAM model, a UART handshake model and a byte/address
//                scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_sample_streamer;

    localparam int AW = 10;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] end_address;
    logic          busy;
    logic          done;
    logic          error;

    uart_sample_streamer_if #(.ADDR_W(AW)) bus ();

    uart_sample_streamer #(
        .ADDR_W      (AW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .start       (start),
        .abort       (abort),
        .end_address (end_address),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- sample RAM model ----------------
    logic [15:0] ram [0:(1<<AW)-1];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_address];

    // ---------------- UART model ----------------
    int   u_drop;
    int   u_busy;
    logic u_stuck;
    logic u_force_low;
    logic u_rdy;
    int   u_ph;
    int   u_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_rdy <= 1'b1;
            u_ph  <= 0;
            u_cnt <= 0;
        end else begin
            case (u_ph)
                0: if (bus.transmit_en && !u_stuck) begin
                    if (u_drop <= 1) begin
                        u_rdy <= 1'b0; u_ph <= 2; u_cnt <= u_busy;
                    end else begin
                        u_ph <= 1; u_cnt <= u_drop - 1;
                    end
                end
                1: if (u_cnt == 1) begin
                    u_rdy <= 1'b0; u_ph <= 2; u_cnt <= u_busy;
                end else u_cnt <= u_cnt - 1;
                default: if (u_cnt <= 1) begin
                    u_rdy <= 1'b1; u_ph <= 0;
                end else u_cnt <= u_cnt - 1;
            endcase
        end
    end
    assign bus.transmit_rdy = u_rdy & ~u_force_low;

    // ---------------- scoreboard / monitor ----------------
    int          n_cmp;
    int          n_fail;
    logic [7:0]  exp_bytes [$];
    int          exp_addr  [$];
    int          en_count, rd_count, done_count;
    int          first_en_cyc, err_cyc, start_cyc;
    logic [7:0]  last_b0, last_b1;
    logic        prev_en, prev_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        prev_en  = 1'b0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.transmit_en) begin
                    en_count++;
                    if (first_en_cyc < 0) first_en_cyc = cyc;
                    check("en_spacing", 32'(prev_en), 0);
                    check("uart_idle_at_req", (u_ph == 0 && bus.transmit_rdy) ? 1 : 0, 1);
                    if (exp_bytes.size() == 0) check("byte_extra", 32'(bus.data_out), 32'hFFFF);
                    else check("tx_byte", 32'(bus.data_out), 32'(exp_bytes.pop_front()));
                    last_b1 = last_b0;
                    last_b0 = bus.data_out;
                end
                if (bus.rd_en) begin
                    rd_count++;
                    if (exp_addr.size() == 0) check("rd_extra", 32'(bus.rd_address), 32'hFFFF);
                    else check("rd_addr", 32'(bus.rd_address), 32'(exp_addr.pop_front()));
                end
                if (done) begin
                    done_count++;
                    check("done_busy_low", 32'(busy), 0);
                end
                if (error && !prev_err) err_cyc = cyc;
                prev_en  = bus.transmit_en;
                prev_err = error;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_sb();
        exp_bytes.delete();
        exp_addr.delete();
        en_count = 0; rd_count = 0; done_count = 0;
        first_en_cyc = -1; err_cyc = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_ram(input int pat, input int n);
        for (int i = 0; i < n; i++) begin
            case (pat)
                0: ram[i] = 16'hA55A;
                1: ram[i] = (i == 0) ? 16'h1234 : (i == 1) ? 16'hBEEF : 16'h0001;
                2: ram[i] = 16'(i);
                default: ram[i] = 16'(i * 32'h1111) ^ 16'h8001;
            endcase
        end
    endtask

    task automatic push_expect(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            logic [15:0] w;
            w = ram[a];
            exp_addr.push_back(a);
            exp_bytes.push_back(w[7:0]);
            exp_bytes.push_back(w[15:8]);
        end
    endtask

    task automatic pulse_start(input int ea, input logic ab);
        @(posedge clk); #1;
        end_address = AW'(ea);
        start = 1'b1;
        abort = ab;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_count == 0 && k < budget) begin @(posedge clk); k++; end
        #1;
        check("done_within_budget", (done_count != 0) ? 1 : 0, 1);
    endtask

    typedef struct {
        int         end_addr;
        int         pat;
        int         drop;
        int         busy_len;
        int         exp_pulses;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; end_address = '0;
        u_drop = 2; u_busy = 1; u_stuck = 1'b0; u_force_low = 1'b0;
        last_b0 = 8'h00; last_b1 = 8'h00;
        clear_sb();

        vecs[0] = '{end_addr: 0,    pat: 0, drop: 2, busy_len: 100, exp_pulses: 2,    exp_lo: 8'h5A, exp_hi: 8'hA5};
        vecs[1] = '{end_addr: 2,    pat: 1, drop: 2, busy_len: 5,   exp_pulses: 6,    exp_lo: 8'h01, exp_hi: 8'h00};
        vecs[2] = '{end_addr: 7,    pat: 3, drop: 3, busy_len: 1,   exp_pulses: 16,   exp_lo: 8'h76, exp_hi: 8'hF7};
        vecs[3] = '{end_addr: 1023, pat: 2, drop: 2, busy_len: 1,   exp_pulses: 2048, exp_lo: 8'hFF, exp_hi: 8'h03};

        // Reset state
        wait_cycles(3);
        check("reset_outputs", 32'({bus.rd_en, bus.rd_address, bus.data_out, bus.transmit_en, busy, done, error}), 0);
        rst_n = 1'b1;
        wait_cycles(2);
        check("idle_busy", 32'(busy), 0);

        // Table-driven streams
        for (int i = 0; i < 4; i++) begin
            clear_sb();
            load_ram(vecs[i].pat, vecs[i].end_addr + 1);
            push_expect(0, vecs[i].end_addr);
            u_drop = vecs[i].drop;
            u_busy = vecs[i].busy_len;
            pulse_start(vecs[i].end_addr, 1'b0);
            wait_done(40000);
            wait_cycles(2);
            check("pulse_count", 32'(en_count), 32'(vecs[i].exp_pulses));
            check("done_count", 32'(done_count), 1);
            check("first_req_latency", 32'(first_en_cyc - start_cyc), 3);
            check("bytes_left", 32'(exp_bytes.size()), 0);
            check("reads_left", 32'(exp_addr.size()), 0);
            check("last_pair", {16'h0, last_b1, last_b0}, {16'h0, vecs[i].exp_lo, vecs[i].exp_hi});
            check("busy_after", 32'(busy), 0);
            check("error_clear", 32'(error), 0);
        end

        // SEND holds while transmitter not ready
        clear_sb();
        ram[0] = 16'h1234;
        push_expect(0, 0);
        u_drop = 2; u_busy = 3; u_force_low = 1'b1;
        pulse_start(0, 1'b0);
        wait_cycles(10);
        check("hold_no_req", 32'(en_count), 0);
        check("hold_busy", 32'(busy), 1);
        u_force_low = 1'b0;
        wait_done(500);
        check("hold_pulses", 32'(en_count), 2);
        check("hold_bytes_left", 32'(exp_bytes.size()), 0);

        // Acknowledge timeout
        clear_sb();
        ram[0] = 16'hC3D2;
        exp_addr.push_back(0);
        exp_bytes.push_back(8'hD2);
        u_stuck = 1'b1;
        pulse_start(5, 1'b0);
        begin
            int k = 0;
            while (!error && k < 200) begin @(posedge clk); k++; end
        end
        wait_cycles(3);
        check("to_error", 32'(error), 1);
        check("to_busy", 32'(busy), 0);
        check("to_pulses", 32'(en_count), 1);
        check("to_no_done", 32'(done_count), 0);
        check("to_latency", 32'(err_cyc - first_en_cyc), 32'(TO + 1));
        check("to_reads", 32'(rd_count), 1);
        u_stuck = 1'b0;
        clear_sb();
        push_expect(0, 0);
        pulse_start(0, 1'b0);
        check("error_cleared_by_start", 32'(error), 0);
        wait_done(500);
        check("after_to_pulses", 32'(en_count), 2);

        // Abort in WAIT_DONE of sample 1 high byte
        clear_sb();
        load_ram(3, 4);
        push_expect(0, 1);
        u_drop = 2; u_busy = 20;
        pulse_start(3, 1'b0);
        begin
            int k = 0;
            while (en_count < 4 && k < 500) begin @(posedge clk); k++; end
            k = 0;
            while (bus.transmit_rdy && k < 50) begin @(posedge clk); k++; end
        end
        wait_cycles(3);
        check("abort_pre_busy", 32'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle_next", 32'(busy), 0);
        wait_cycles(100);
        check("abort_pulses", 32'(en_count), 4);
        check("abort_reads", 32'(rd_count), 2);
        check("abort_no_done", 32'(done_count), 0);
        check("abort_bytes_left", 32'(exp_bytes.size()), 0);

        // Asynchronous reset mid-stream
        clear_sb();
        ram[0] = 16'h7E81;
        push_expect(0, 0);
        u_drop = 2; u_busy = 30;
        pulse_start(0, 1'b0);
        wait_cycles(6);
        check("pre_reset_state", {23'h0, busy, bus.data_out}, {23'h0, 1'b1, 8'h81});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({bus.rd_en, bus.rd_address, bus.data_out, bus.transmit_en, busy, done, error}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(2);

        // start and abort together in IDLE
        clear_sb();
        pulse_start(5, 1'b1);
        check("collide_busy", 32'(busy), 0);
        wait_cycles(5);
        check("collide_still_idle", 32'({busy, rd_count[0], en_count[0]}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
